// File: rtl/snn_spike_layer.sv
// Single-layer integrate-and-fire core: registered spike inputs, writable signed weight
// matrix, saturating potentials, refractory counters and sticky spike flags.
// Optional leak toward zero is compiled in when SNN_LEAK_EN is defined.
module snn_spike_layer #(
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_NEURONS = 4,
   parameter int WEIGHT_SIZE = 8,
   parameter int POT_SIZE    = 16,
   parameter int THRESH      = 4,
   parameter int RESET       = 0,
   parameter int REFRAC      = 0,
   parameter int LEAK        = 1
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic [NUM_INPUTS-1:0]                                spike_in,
   input  logic                                                 wr_en,
   input  logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] wr_neuron,
   input  logic [((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0]   wr_input,
   input  logic [WEIGHT_SIZE-1:0]                               wr_data,
   input  logic [NUM_NEURONS-1:0]                               flag_clr,
   output logic [NUM_NEURONS-1:0]                               spike_out,
   output logic [NUM_NEURONS-1:0]                               spike_flag
);

   localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

   localparam logic signed [POT_SIZE:0]   L_POT_MAX = {2'b00, {(POT_SIZE-1){1'b1}}};
   localparam logic signed [POT_SIZE:0]   L_POT_MIN = {2'b11, {(POT_SIZE-1){1'b0}}};
   localparam logic signed [POT_SIZE-1:0] L_THRESH  = POT_SIZE'(THRESH);
   localparam logic signed [POT_SIZE-1:0] L_RESET   = POT_SIZE'(RESET);
   localparam logic [RW-1:0]              L_REFRAC  = RW'(REFRAC);

   logic [NUM_INPUTS-1:0]         r_spike_q;
   logic signed [WEIGHT_SIZE-1:0] r_weight [NUM_NEURONS][NUM_INPUTS];
   logic signed [POT_SIZE-1:0]    r_pot    [NUM_NEURONS];
   logic [RW-1:0]                 r_refrac [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]        r_spike_out;
   logic [NUM_NEURONS-1:0]        r_flag;

   logic signed [POT_SIZE-1:0]    w_sum    [NUM_NEURONS];
   logic signed [POT_SIZE-1:0]    w_v_base [NUM_NEURONS];
   logic signed [POT_SIZE:0]      w_v_wide [NUM_NEURONS];
   logic signed [POT_SIZE-1:0]    w_v_next [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]        w_fire;

   function automatic logic signed [POT_SIZE-1:0] f_sext(input logic signed [WEIGHT_SIZE-1:0] w);
      f_sext = {{(POT_SIZE-WEIGHT_SIZE){w[WEIGHT_SIZE-1]}}, w};
   endfunction

`ifdef SNN_LEAK_EN
   localparam logic signed [POT_SIZE-1:0] L_LEAK = POT_SIZE'(LEAK);

   function automatic logic signed [POT_SIZE-1:0] f_leak(input logic signed [POT_SIZE-1:0] v);
      if (v > L_LEAK) begin
         f_leak = v - L_LEAK;
      end else if (v < -L_LEAK) begin
         f_leak = v + L_LEAK;
      end else begin
         f_leak = {POT_SIZE{1'b0}};
      end
   endfunction
`endif

   // Weighted sum, optional leak, saturating add and threshold decision per neuron
   always_comb begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
         w_sum[n] = {POT_SIZE{1'b0}};
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_spike_q[i]) begin
               w_sum[n] = w_sum[n] + f_sext(r_weight[n][i]);
            end else begin
               w_sum[n] = w_sum[n];
            end
         end
`ifdef SNN_LEAK_EN
         w_v_base[n] = f_leak(r_pot[n]);
`else
         w_v_base[n] = r_pot[n];
`endif
         // One extra bit holds the true sum so both rails can be detected
         w_v_wide[n] = {w_v_base[n][POT_SIZE-1], w_v_base[n]} + {w_sum[n][POT_SIZE-1], w_sum[n]};
         if (w_v_wide[n] > L_POT_MAX) begin
            w_v_next[n] = L_POT_MAX[POT_SIZE-1:0];
         end else if (w_v_wide[n] < L_POT_MIN) begin
            w_v_next[n] = L_POT_MIN[POT_SIZE-1:0];
         end else begin
            w_v_next[n] = w_v_wide[n][POT_SIZE-1:0];
         end
         w_fire[n] = (r_refrac[n] == {RW{1'b0}}) && (w_v_next[n] >= L_THRESH);
      end
   end

   // Input capture and weight memory; integration sees the pre-write weight on a shared edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_spike_q <= {NUM_INPUTS{1'b0}};
         for (int n = 0; n < NUM_NEURONS; n++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
               r_weight[n][i] <= {WEIGHT_SIZE{1'b0}};
            end
         end
      end else begin
         r_spike_q <= spike_in;
         for (int n = 0; n < NUM_NEURONS; n++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
               if (wr_en && (int'(wr_neuron) == n) && (int'(wr_input) == i)) begin
                  r_weight[n][i] <= wr_data;
               end
            end
         end
      end
   end

   // Membrane potential, refractory counter and fire pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_spike_out <= {NUM_NEURONS{1'b0}};
         for (int n = 0; n < NUM_NEURONS; n++) begin
            r_pot[n]    <= L_RESET;
            r_refrac[n] <= {RW{1'b0}};
         end
      end else begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            if (r_refrac[n] != {RW{1'b0}}) begin
               r_refrac[n]    <= r_refrac[n] - {{(RW-1){1'b0}}, 1'b1};
               r_pot[n]       <= L_RESET;
               r_spike_out[n] <= 1'b0;
            end else if (w_fire[n]) begin
               r_refrac[n]    <= L_REFRAC;
               r_pot[n]       <= L_RESET;
               r_spike_out[n] <= 1'b1;
            end else begin
               r_pot[n]       <= w_v_next[n];
               r_spike_out[n] <= 1'b0;
            end
         end
      end
   end

   // Sticky flags: a spike on the same edge overrides a clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flag <= {NUM_NEURONS{1'b0}};
      end else begin
         r_flag <= w_fire | (r_flag & ~flag_clr);
      end
   end

   assign spike_out  = r_spike_out;
   assign spike_flag = r_flag;

endmodule

// File: doc/snn_spike_layer.md
# snn_spike_layer

Parametrised single-layer integrate-and-fire block: `NUM_INPUTS` spike inputs fully connected through a run-time-writable signed weight matrix to `NUM_NEURONS` neurons, each with saturating membrane potential, threshold, reset value and refractory counter. Registered input sampling, one-cycle output spike pulses and per-neuron sticky spike flags are cleared by software. It is the next-generation FPGA top-level spike core, replacing the fixed single-input/single-neuron configuration with a generalised layer that is loadable over a simple write port.

## Interface
- `NUM_INPUTS`, 4: number of spike inputs (≥1).
- `NUM_NEURONS`, 4: number of neurons (≥1).
- `WEIGHT_SIZE`, 8: signed weight width.
- `POT_SIZE`, 16: signed membrane potential width (≥ `WEIGHT_SIZE` + clog2(`NUM_INPUTS`) + 1).
- `THRESH`, 4: fire when potential ≥ `THRESH` (signed).
- `RESET`, 0: potential value after firing and during reset.
- `REFRAC`, 0: refractory cycles after a spike.
- `LEAK`, 1: per-cycle leak magnitude (used only with `SNN_LEAK_EN`).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `spike_in` in `NUM_INPUTS`: raw spike levels, one per input.
- `wr_en` in 1: weight write strobe.
- `wr_neuron` in max(1,clog2(`NUM_NEURONS`)): target neuron index.
- `wr_input` in max(1,clog2(`NUM_INPUTS`)): target input index.
- `wr_data` in `WEIGHT_SIZE`: signed weight value.
- `flag_clr` in `NUM_NEURONS`: per-neuron sticky flag clear.
- `spike_out` out `NUM_NEURONS`: one-cycle fire pulse per neuron.
- `spike_flag` out `NUM_NEURONS`: sticky per-neuron "has fired" flag.

## Operation
- **Input stage:** `spike_in` is registered once into `spike_q` every cycle. Only `spike_q` feeds integration.
- **Integration, per neuron n, each cycle:**
  - `sum_n` = signed sum of `w[n][i]` over every i where `spike_q[i]` = 1.
  - Arithmetic is at `POT_SIZE` bits with sign extension.
- **Refractory (`refrac_n` > 0):**
  - `refrac_n` decrements.
  - Potential is held at `RESET`.
  - `sum_n` is discarded and no spike is produced.
- **Otherwise:**
  - `v_next` = sat(`v_n` + `sum_n`), clamped to the `POT_SIZE` signed range [−2^(P−1), 2^(P−1)−1].
  - If `v_next` ≥ `THRESH`: `spike_out[n]` = 1 for one cycle, `v_n` ← `RESET`, `refrac_n` ← `REFRAC`.
  - Else: `v_n` ← `v_next`.
- **Weight write:** when `wr_en` = 1, `w[wr_neuron][wr_input]` ← `wr_data` at the edge. Out-of-range indices are ignored.
- **Write/integrate collision:** a write and an integration of the same weight on the same edge use the old weight. The new weight applies from the next edge.
- **Sticky flag:**
  - `spike_flag[n]` sets when `spike_out[n]` asserts.
  - `flag_clr[n]` clears it.
  - Simultaneous set and clear: set wins.
- **Reset** (asynchronous, `rst` = 0):
  - `spike_q`, all weights, `refrac_n`, `spike_out` and `spike_flag` go to 0.
  - All potentials go to `RESET`.
  - Reset mid-integration discards all state immediately.
  - Operation resumes on the first rising edge after `rst` returns to 1.

## Timing
- `spike_in` high before edge k is captured into `spike_q` at edge k and integrated at edge k+1.
- The earliest resulting `spike_out` is high from edge k+1 to edge k+2. Input-to-spike latency is 2 cycles.
- `spike_out` is registered and never high on two consecutive cycles while `REFRAC` ≥ 1.
- With `REFRAC` = 0, a neuron may fire on consecutive cycles if `RESET` + `sum_n` ≥ `THRESH`.
- `spike_flag` rises in the same cycle as `spike_out`.
- A `flag_clr` pulse at edge j clears the flag at edge j unless a spike sets it at j.
- Weight write latency: a write at edge j affects integration from edge j+1.
- No backpressure; every input cycle is consumed.

## Configuration
- `SNN_LEAK_EN` defined:
  - Before summing, a non-refractory potential moves `LEAK` toward 0: `v`−`LEAK` if `v` > `LEAK`, `v`+`LEAK` if `v` < −`LEAK`, else 0.
  - Then `v_next` = sat(`v_leaked` + `sum_n`).
- `SNN_LEAK_EN` undefined:
  - Pure integrate-and-fire; the `LEAK` parameter has no effect.
  - No leak logic is synthesised.

## Test plan
- Reset, then write `w[0][0]` = 1, hold `spike_in[0]` = 1 (defaults, no leak) -> `spike_out[0]` pulses at the 4th integration edge after capture, then every 4 cycles. `spike_flag[0]` = 1. Other neurons stay silent.
- `REFRAC` = 3, `w[1][0]` = 4, `spike_in[0]` held -> `spike_out[1]` pulses once every 4 cycles. Potential reads `RESET` during the 3 refractory cycles.
- `w[2][0]` = 127, `w[2][1]` = 127 with `POT_SIZE` = 8 and `THRESH` = 127, both inputs high -> potential saturates at 127, a spike fires, no wrap-around.
- Negative weight `w[3][0]` = −2, input held, `THRESH` = 4 -> potential decreases monotonically to −32768 and clamps there. No spike.
- With `SNN_LEAK_EN`, `LEAK` = 1, `w[0][0]` = 3, single input pulse -> potential reads 3, 2, 1, 0, 0 over successive cycles. No spike.
- Mid-run assert `rst` = 0 asynchronously -> all outputs are 0 before the next edge. Weights are cleared. A same-edge `flag_clr` plus spike leaves the flag set.
